mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32, width of the cycle and retire counters.
REQ-002 Parameter TIMEOUT, default 16, maximum wait cycles for a memory ready before error.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 jump_type  input  3  decoder jump class: 000 NOP, 001 BEQ, 010 JAL, 011 JR, 100 J; others treated as NOP.
REQ-006 we_regfile_dec / we_dmem_dec / en_rdata_dec  input  1 each  decoder register-write, store and load flags.
REQ-007 beq_taken  input  1  rs1==rs2 compare result from datapath.
REQ-008 imem_ready / dmem_ready  input  1 each  memory completion strobes.
REQ-009 halt_req  input  1  request to stop at next instruction boundary.
REQ-010 imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we  output  1 each  datapath strobes.
REQ-011 pc_sel  output  1  0 = pc+4, 1 = jump/branch target.
REQ-012 state  output  3  current FSM state encoding.
REQ-013 halted, err  output  1 each  halt indication; sticky timeout error.
REQ-014 cycle_cnt, retire_cnt  output  DWIDTH each  non-halted cycles; retired instructions.

Function
REQ-015 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT with err=1.
REQ-016 FETCH: if halt_req -> HALT, no imem_req; else imem_req=1; on imem_ready ir_we=1 same cycle, -> DECODE.
REQ-017 DECODE: no strobes; unconditionally -> EXEC next cycle.
REQ-018 EXEC, BEQ: pc_we=1, pc_sel=beq_taken, -> FETCH.
REQ-019 EXEC, J/JR: pc_we=1, pc_sel=1, -> FETCH; JAL additionally rf_we=1.
REQ-020 EXEC, NOP class: if we_dmem_dec or en_rdata_dec -> MEM; else if we_regfile_dec -> WB; else pc_we=1, pc_sel=0, -> FETCH.
REQ-021 MEM: dmem_req=1, dmem_we=we_dmem_dec; on dmem_ready: if en_rdata_dec -> WB, else pc_we=1, pc_sel=0, -> FETCH.
REQ-022 WB: rf_we=1, pc_we=1, pc_sel=0, -> FETCH.
REQ-023 Strobes SHALL be combinational from state and inputs, each asserted at most one cycle per instruction (req signals held while waiting).
REQ-024 Wait counter: cleared on entering FETCH/MEM, increments each cycle req is high without ready; reaching TIMEOUT SHALL set err=1 and -> HALT, no strobe that cycle.
REQ-025 Ready arriving in the same cycle the counter would reach TIMEOUT SHALL win (normal completion).
REQ-026 retire_cnt increments by 1 on every cycle pc_we=1; cycle_cnt increments every cycle state != HALT; both wrap modulo 2^DWIDTH.
REQ-027 HALT: all strobes 0, halted=1, counters frozen; exit only via rst.
REQ-028 halt_req outside FETCH SHALL be ignored until the next FETCH.
REQ-029 Ready inputs outside their wait state SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately force state=FETCH, counters 0, wait counter 0, err=0, halted=0, all strobes 0 while rst high.
REQ-031 rst asserted mid-MEM or mid-WB SHALL abort with no rf_we, dmem_we or pc_we emitted.
REQ-032 First imem_req SHALL appear the first cycle after rst deasserts.

Verification
REQ-033 ALU op (we_regfile_dec=1), readies tied 1 -> states 0,1,2,4 then 0; rf_we and pc_we in cycle 4; retire_cnt=1, cycle_cnt=4.
REQ-034 Load (en_rdata_dec=1), dmem_ready delayed 3 cycles -> MEM lasts 4 cycles, total 8 cycles, one rf_we, retire_cnt=1.
REQ-035 Store then BEQ with beq_taken=1 -> store 4 cycles with dmem_we=1 once; BEQ 3 cycles, pc_sel=1 at pc_we; retire_cnt=2.
REQ-036 imem_ready held 0 -> err=1, state=5 after exactly 16 FETCH cycles; cycle_cnt frozen at 16.
REQ-037 halt_req pulsed during EXEC of JAL -> JAL completes (rf_we=1, pc_sel=1); halt_req held -> HALT at next FETCH, halted=1.
REQ-038 rst asserted in MEM with dmem_ready=1 same cycle -> no dmem_we/pc_we; state=0, retire_cnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle processor control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB]
// and drives the datapath strobes combinationally from the current state and
// the decoder/memory inputs. Memory waits are bounded by a wait counter; a
// wait that reaches TIMEOUT cycles raises a sticky error and parks the FSM in
// HALT, which can only be left through rst.
//
// Parameters
//   DWIDTH   width of cycle_cnt / retire_cnt
//   TIMEOUT  maximum wait cycles for imem_ready / dmem_ready
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   jump_type[2:0]              000 NOP, 001 BEQ, 010 JAL, 011 JR, 100 J
//   we_regfile_dec              decoded instruction writes the register file
//   we_dmem_dec                 decoded instruction stores to data memory
//   en_rdata_dec                decoded instruction loads from data memory
//   beq_taken                   rs1 == rs2 compare result
//   imem_ready, dmem_ready      memory completion strobes
//   halt_req                    stop at the next instruction boundary
//   imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we   datapath strobes
//   pc_sel                      0 = pc+4, 1 = jump/branch target
//   state[2:0]                  current FSM state code
//   halted, err                 halt indication, sticky timeout error
//   cycle_cnt, retire_cnt       non-halted cycles, retired instructions
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        jump_type,
    input  logic              we_regfile_dec,
    input  logic              we_dmem_dec,
    input  logic              en_rdata_dec,
    input  logic              beq_taken,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              halt_req,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_we,
    output logic              rf_we,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [2:0]        state,
    output logic              halted,
    output logic              err,
    output logic [DWIDTH-1:0] cycle_cnt,
    output logic [DWIDTH-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // The counter only ever holds 0..TIMEOUT-1: the wait that would reach
    // TIMEOUT leaves the wait state instead of storing the value.
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t             state_r;
    state_t             next_s;
    logic [WCW-1:0]     wcnt_r;
    logic               err_r;
    logic [DWIDTH-1:0]  cycle_cnt_r;
    logic [DWIDTH-1:0]  retire_cnt_r;

    logic imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, rf_we_s, pc_we_s, pc_sel_s;
    logic timeout_s;
    logic bad_state_s;

    // Next-state and strobe decode for the current state.
    always_comb begin
        next_s      = state_r;
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        ir_we_s     = 1'b0;
        rf_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        pc_sel_s    = 1'b0;
        timeout_s   = 1'b0;
        bad_state_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (halt_req) begin
                    next_s = S_HALT;
                end else begin
                    imem_req_s = 1'b1;
                    // A ready on the last allowed wait cycle still completes.
                    if (imem_ready) begin
                        ir_we_s = 1'b1;
                        next_s  = S_DECODE;
                    end else if (wcnt_r == WAIT_LAST) begin
                        timeout_s = 1'b1;
                        next_s    = S_HALT;
                    end else begin
                        next_s = S_FETCH;
                    end
                end
            end
            S_DECODE: begin
                next_s = S_EXEC;
            end
            S_EXEC: begin
                case (jump_type)
                    3'b001: begin
                        pc_we_s  = 1'b1;
                        pc_sel_s = beq_taken;
                        next_s   = S_FETCH;
                    end
                    3'b010: begin
                        pc_we_s  = 1'b1;
                        pc_sel_s = 1'b1;
                        rf_we_s  = 1'b1;
                        next_s   = S_FETCH;
                    end
                    3'b011, 3'b100: begin
                        pc_we_s  = 1'b1;
                        pc_sel_s = 1'b1;
                        next_s   = S_FETCH;
                    end
                    default: begin
                        // NOP class, including the unused jump codes.
                        if (we_dmem_dec || en_rdata_dec) begin
                            next_s = S_MEM;
                        end else if (we_regfile_dec) begin
                            next_s = S_WB;
                        end else begin
                            pc_we_s = 1'b1;
                            next_s  = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = we_dmem_dec;
                if (dmem_ready) begin
                    if (en_rdata_dec) begin
                        next_s = S_WB;
                    end else begin
                        pc_we_s = 1'b1;
                        next_s  = S_FETCH;
                    end
                end else if (wcnt_r == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    next_s    = S_HALT;
                end else begin
                    next_s = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s = 1'b1;
                pc_we_s = 1'b1;
                next_s  = S_FETCH;
            end
            S_HALT: begin
                next_s = S_HALT;
            end
            default: begin
                // Codes 6 and 7 are not legal states.
                bad_state_s = 1'b1;
                next_s      = S_HALT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Wait counter: cleared on any state change, counts unanswered requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r <= '0;
        end else if (next_s != state_r) begin
            wcnt_r <= '0;
        end else if (imem_req_s || dmem_req_s) begin
            wcnt_r <= wcnt_r + WCW'(1);
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (timeout_s || bad_state_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Performance counters; both freeze once the FSM sits in HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r  <= '0;
            retire_cnt_r <= '0;
        end else begin
            if (state_r != S_HALT) begin
                cycle_cnt_r <= cycle_cnt_r + DWIDTH'(1);
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (pc_we_s) begin
                retire_cnt_r <= retire_cnt_r + DWIDTH'(1);
            end else begin
                retire_cnt_r <= retire_cnt_r;
            end
        end
    end

    // The async reset already forces FETCH, whose decode would raise
    // imem_req; gating with rst keeps every strobe low while reset is held
    // and kills any write strobe of an aborted MEM/WB cycle at once.
    assign imem_req   = imem_req_s & ~rst;
    assign dmem_req   = dmem_req_s & ~rst;
    assign dmem_we    = dmem_we_s  & ~rst;
    assign ir_we      = ir_we_s    & ~rst;
    assign rf_we      = rf_we_s    & ~rst;
    assign pc_we      = pc_we_s    & ~rst;
    assign pc_sel     = pc_sel_s   & ~rst;
    assign state      = state_r;
    assign halted     = (state_r == S_HALT);
    assign err        = err_r;
    assign cycle_cnt  = cycle_cnt_r;
    assign retire_cnt = retire_cnt_r;

endmodule
